// File: rtl/complement_pipe.sv
// complement_pipe: N-lane sign/magnitude <-> two's-complement converter.
// Two register stages (S1 capture, S2 convert/output) with valid/ready flow
// control. mode=0 converts SM->TC, mode=1 converts TC->SM; each lane has a
// sign-flip input. Optional macro COMPLEMENT_SAT_CNT_EN adds a saturating
// 16-bit counter of saturated lanes in accepted output beats.
module complement_pipe #(
    parameter int LANES      = 4,
    parameter int sigWidth   = 4,
    parameter int low_expand = 2,
    localparam int W         = sigWidth + 4 + low_expand
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [LANES-1:0]     sign,
    input  logic [W*LANES-1:0]   input_num,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*LANES-1:0]   result_num,
    output logic [LANES-1:0]     sat
`ifdef COMPLEMENT_SAT_CNT_EN
    ,
    output logic [15:0]          sat_cnt
`endif
);

    // Per-lane conversion; returns {sat, result}.
    function automatic logic [W:0] convert_lane(
        input logic         md,
        input logic         neg,
        input logic         zero,
        input logic [W-1:0] v
    );
        logic [W-2:0] neg_m;
        logic [W-1:0] mag;
        logic [W:0]   r;
        neg_m = ~v[W-2:0] + {{(W-2){1'b0}}, 1'b1};
        mag   = v[W-1] ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
        r     = {(W+1){1'b0}};
        if (zero) begin
            // Negative zero and true zero both map to all zeros.
            r = {(W+1){1'b0}};
        end else if (!md) begin
            if (neg) begin
                r = {1'b0, 1'b1, neg_m};
            end else begin
                r = {1'b0, 1'b0, v[W-2:0]};
            end
        end else begin
            if (v[W-1] && (v[W-2:0] == {(W-1){1'b0}})) begin
                // Most negative value has no SM magnitude: clamp and flag.
                r = {1'b1, neg, {(W-1){1'b1}}};
            end else begin
                r = {1'b0, neg, mag[W-2:0]};
            end
        end
        return r;
    endfunction

    logic                 s1_valid_r;
    logic                 s1_mode_r;
    logic [W*LANES-1:0]   s1_data_r;
    logic [LANES-1:0]     s1_neg_r;
    logic [LANES-1:0]     s1_zero_r;

    logic                 s2_adv_s;
    logic                 s1_adv_s;
    logic [LANES-1:0]     s1_neg_s;
    logic [LANES-1:0]     s1_zero_s;
    logic [W*LANES-1:0]   s2_res_s;
    logic [LANES-1:0]     s2_sat_s;

    // Stage advance conditions; in_ready follows out_ready combinationally.
    always_comb begin
        s2_adv_s = !out_valid || out_ready;
        s1_adv_s = !s1_valid_r || s2_adv_s;
        in_ready = s1_adv_s;
    end

    // S1 per-lane effective sign and zero-magnitude detection (no arithmetic).
    always_comb begin
        s1_neg_s  = {LANES{1'b0}};
        s1_zero_s = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            s1_neg_s[i] = sign[i] ^ input_num[W*i + W-1];
            if (mode) begin
                s1_zero_s[i] = (input_num[W*i +: W] == {W{1'b0}});
            end else begin
                s1_zero_s[i] = (input_num[W*i +: (W-1)] == {(W-1){1'b0}});
            end
        end
    end

    // S1 capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_mode_r  <= 1'b0;
            s1_data_r  <= {(W*LANES){1'b0}};
            s1_neg_r   <= {LANES{1'b0}};
            s1_zero_r  <= {LANES{1'b0}};
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_mode_r <= mode;
                s1_data_r <= input_num;
                s1_neg_r  <= s1_neg_s;
                s1_zero_r <= s1_zero_s;
            end
        end
    end

    // S2 conversion of every lane from the S1 contents.
    always_comb begin
        logic [W:0] lane_r;
        s2_res_s = {(W*LANES){1'b0}};
        s2_sat_s = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            lane_r = convert_lane(s1_mode_r, s1_neg_r[i], s1_zero_r[i],
                                  s1_data_r[W*i +: W]);
            s2_res_s[W*i +: W] = lane_r[W-1:0];
            s2_sat_s[i]        = lane_r[W];
        end
    end

    // S2 output register; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            result_num <= {(W*LANES){1'b0}};
            sat        <= {LANES{1'b0}};
        end else if (s2_adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                result_num <= s2_res_s;
                sat        <= s2_sat_s;
            end
        end
    end

`ifdef COMPLEMENT_SAT_CNT_EN
    // Number of set flags in a lane vector.
    function automatic logic [16:0] popcount(input logic [LANES-1:0] f);
        logic [16:0] c;
        c = 17'd0;
        for (int i = 0; i < LANES; i++) begin
            c = c + {16'd0, f[i]};
        end
        return c;
    endfunction

    logic [16:0] sat_sum_s;

    // Candidate counter value before clamping.
    always_comb begin
        sat_sum_s = {1'b0, sat_cnt} + popcount(sat);
    end

    // Saturating count of flagged lanes in accepted output beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            sat_cnt <= sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
        end
    end
`else
`endif

endmodule

// File: tb/tb_complement_pipe.sv
// Self-checking scoreboard bench for complement_pipe (default parameters).
module tb_complement_pipe;
    localparam int L = 4;
    localparam int W = 10;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, mode, out_valid, out_ready;
    logic [L-1:0]     sign, sat;
    logic [W*L-1:0]   input_num, result_num;
`ifdef COMPLEMENT_SAT_CNT_EN
    logic [15:0]      sat_cnt;
    int unsigned      exp_cnt = 0;
`endif

    always #5 clk = ~clk;

    complement_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sign(sign), .input_num(input_num),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_num(result_num), .sat(sat)
`ifdef COMPLEMENT_SAT_CNT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    typedef struct {
        logic [W*L-1:0] res;
        logic [L-1:0]   sat;
        int             cyc;
    } exp_t;

    exp_t           sb[$];
    int             checks = 0, failures = 0, cyc = 0;
    bit             lat_chk = 1, bp_active = 0, rnd_ready = 0, contig_chk = 0;
    int             bp_cnt = 0, acc_total = 0, first_block = -1;
    bit             prev_stall = 0, last_acc = 0;
    logic [W*L-1:0] prev_res, pend_res;
    logic [L-1:0]   prev_sat, pend_sat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference lane model written from the conversion rules.
    function automatic logic [W:0] lane_model(input bit md, input bit s, input logic [W-1:0] v);
        int  m, sv, r;
        bit  neg, st;
        neg = s ^ v[W-1];
        st  = 0;
        if (!md) begin
            m = int'(v[W-2:0]);
            if (m == 0) r = 0;
            else        r = neg ? ((1 << W) - m) : m;
        end else begin
            sv = v[W-1] ? int'(v) - (1 << W) : int'(v);
            if (sv == 0) r = 0;
            else if (sv == -(1 << (W-1))) begin
                r  = (neg ? (1 << (W-1)) : 0) + (1 << (W-1)) - 1;
                st = 1;
            end else begin
                r = (neg ? (1 << (W-1)) : 0) + (sv < 0 ? -sv : sv);
            end
        end
        return {st, r[W-1:0]};
    endfunction

    task automatic model_beat(input bit md, input logic [L-1:0] s, input logic [W*L-1:0] d);
        logic [W:0] lr;
        for (int i = 0; i < L; i++) begin
            lr = lane_model(md, s[i], d[W*i +: W]);
            pend_res[W*i +: W] = lr[W-1:0];
            pend_sat[i]        = lr[W];
        end
    endtask

    // One clock cycle: called at the falling edge with inputs already set.
    task automatic tick();
        bit   ai, ao;
        exp_t e;
        if (bp_active) out_ready = (bp_cnt >= 4);
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        ai = in_valid && in_ready;
        ao = out_valid && out_ready;
`ifdef COMPLEMENT_SAT_CNT_EN
        check_val("sat_cnt", sat_cnt, exp_cnt);
`endif
        if (prev_stall) begin
            check_val("valid_held", out_valid, 1);
            check_val("res_stable", result_num, prev_res);
            check_val("sat_stable", sat, prev_sat);
        end
        if (contig_chk && sb.size() > 0) check_val("contig_valid", out_valid, 1);
        if (ao) begin
            check_val("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_val("result", result_num, e.res);
                check_val("sat", sat, e.sat);
                if (lat_chk) check_val("latency", cyc - e.cyc, 2);
`ifdef COMPLEMENT_SAT_CNT_EN
                exp_cnt = exp_cnt + $countones(e.sat);
                if (exp_cnt > 16'hFFFF) exp_cnt = 16'hFFFF;
`endif
            end
        end
        if (bp_active && in_valid && !in_ready && first_block < 0) first_block = acc_total;
        if (bp_active && out_valid && !out_ready) bp_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_res   = result_num;
        prev_sat   = sat;
        if (ai) begin
            e.res = pend_res; e.sat = pend_sat; e.cyc = cyc;
            sb.push_back(e);
            acc_total++;
        end
        last_acc = ai;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input bit md, input logic [L-1:0] s, input logic [W*L-1:0] d,
                        input bit use_exp, input logic [W*L-1:0] eres, input logic [L-1:0] esat,
                        input bit want_first);
        int n;
        in_valid = 1; mode = md; sign = s; input_num = d;
        if (use_exp) begin pend_res = eres; pend_sat = esat; end
        else model_beat(md, s, d);
        n = 0;
        do begin tick(); n++; end while (!last_acc && n < 50);
        check_val("accept_timeout", last_acc, 1);
        if (want_first) check_val("tput_attempts", n, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        int n;
        in_valid = 0;
        n = 0;
        while (sb.size() > 0 && n < 40) begin tick(); n++; end
        check_val("drain_timeout", sb.size(), 0);
    endtask

    function automatic logic [W*L-1:0] rnd_data();
        logic [W*L-1:0] d;
        for (int i = 0; i < L; i++) begin
            case ($urandom_range(0, 5))
                0:       d[W*i +: W] = 10'h200;
                1:       d[W*i +: W] = 10'h000;
                default: d[W*i +: W] = 10'($urandom);
            endcase
        end
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 1; mode = 0; sign = '0; input_num = '0;
        @(negedge clk); @(negedge clk); #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_result", result_num, 0);
        check_val("rst_sat", sat, 0);
        check_val("rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1;

        // Directed vectors with expectations from the conversion rules.
        send(0, 4'b0010, {10'h000, 10'h000, 10'h005, 10'h205}, 1,
             {10'h000, 10'h000, 10'h3FB, 10'h3FB}, 4'b0000, 0);
        send(0, 4'b0101, {4{10'h200}}, 1, 40'h0, 4'b0000, 1);
        send(1, 4'b0100, {10'h000, 10'h200, 10'h200, 10'h3FB}, 1,
             {10'h000, 10'h1FF, 10'h3FF, 10'h205}, 4'b0110, 1);
        drain();

        // Mixed modes back-to-back at full rate.
        for (int i = 0; i < 8; i++) send(i[0], 4'($urandom), rnd_data(), 0, '0, '0, 1);
        drain();

        // Back-pressure: downstream stalls four cycles from first out_valid.
        lat_chk = 0; bp_active = 1; bp_cnt = 0; out_ready = 0;
        first_block = -1; acc_total = 0;
        for (int i = 0; i < 5; i++) send(1'($urandom), 4'($urandom), rnd_data(), 0, '0, '0, 0);
        check_val("bp_buffered", first_block, 2);
        check_val("bp_stall_cycles", bp_cnt, 4);
        bp_active = 0; out_ready = 1; contig_chk = 1;
        drain();
        contig_chk = 0; lat_chk = 1;

        // Reset with two beats in flight.
        send(0, 4'b0000, {4{10'h001}}, 0, '0, '0, 1);
        send(1, 4'b1111, {4{10'h3FF}}, 0, '0, '0, 1);
        check_val("pre_rst_valid", out_valid, 1);
        rst_n = 0; #1;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_result", result_num, 0);
        check_val("mid_rst_sat", sat, 0);
        sb.delete(); prev_stall = 0;
`ifdef COMPLEMENT_SAT_CNT_EN
        exp_cnt = 0;
`endif
        @(negedge clk); rst_n = 1; #1;
        check_val("post_rst_in_ready", in_ready, 1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) tick();
        check_val("no_stale_beat", out_valid, 0);

        // Random traffic with random stalls and gaps.
        lat_chk = 0; rnd_ready = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send(1'($urandom), 4'($urandom), rnd_data(), 0, '0, '0, 0);
        end
        rnd_ready = 0; out_ready = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/complement_pipe.md
Name: complement_pipe

Overview:
- Pipelined, N-lane sign/magnitude <-> two's-complement converter with a per-lane sign-flip input and valid/ready flow control.
- Sits between the GEMM product-alignment stage and the adder tree; the same instance serves the reverse (TC->SM) conversion after accumulation.
- Adds lane-count and width parametrisation, a direction mode, a negative-zero fix, saturation reporting and back-pressure over the 4-lane combinational converter.

Parameters:
- LANES, 4, number of independent lanes
- sigWidth, 4, significand width of the source format
- low_expand, 2, extra low-order guard bits
- W (localparam), sigWidth+4+low_expand, lane width (default 10); MSB is the sign bit

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  converter can accept the beat this cycle
- mode  input  1  0 = SM->TC, 1 = TC->SM; sampled with the beat
- sign  input  LANES  per-lane sign flip (1 = negate value)
- input_num  input  W*LANES  lane i at [W*(i+1)-1 : W*i]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- result_num  output  W*LANES  converted lanes, same packing as input_num
- sat  output  LANES  per-lane saturation flag, aligned with result_num

Behaviour:
- Reset: async assert on rst_n low. s1_valid, out_valid, result_num and sat clear to 0. in_ready is 1 after reset.
- Pipeline: two register stages, S1 and S2 (S2 = output register).
  - Latency: in_valid&&in_ready at cycle t gives out_valid at t+2 when not stalled.
  - Throughput: 1 beat/cycle.
- S1 captures per lane: eff_neg = sign[i] ^ lane MSB, the magnitude-zero flag, raw lane data and mode. It performs no arithmetic.
- S2 performs negation, saturation and zero forcing, and registers result_num/sat.
- Flow control:
  - s2_adv = !out_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; this path is accepted)
  - A beat is transferred only on valid&&ready.
  - Held out_valid keeps result_num/sat stable until accepted.
  - No beat is dropped or duplicated; order is preserved.
- SM->TC (mode 0), per lane, with m = lane[W-2:0]:
  - m==0: output all zeros, whatever the sign bit or flip (negative zero maps to 0).
  - eff_neg=0: output {1'b0, m}.
  - eff_neg=1: output {1'b1, (~m+1)[W-2:0]}.
  - sat is always 0.
- TC->SM (mode 1), per lane, with v = lane and mag = |v| computed in W bits:
  - v==0: output 0.
  - v == 100..0 (-2^(W-1)): magnitude is unrepresentable. Output {eff_neg, {W-1{1'b1}}}, sat[i]=1.
  - Otherwise: output {eff_neg, mag[W-2:0]}, sat=0.
- Lanes are fully independent; mode is per beat and may change every beat.
- Reset mid-stream: in-flight beats are discarded; no output appears after reset release until a new beat is accepted.

Optional Feature:
- Macro: COMPLEMENT_SAT_CNT_EN.
- Defined:
  - Extra output port sat_cnt (16 bits).
  - Counts lanes flagged sat in each accepted output beat (out_valid&&out_ready), adding popcount(sat).
  - Saturates at 16'hFFFF; no wrap.
  - Cleared by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan (defaults, W=10):
- SM->TC: mode=0, lane0=10'h205 (-5), sign=0 -> lane0 result 10'h3FB two cycles later, sat=0; lane1=10'h005, sign[1]=1 -> 10'h3FB.
- Negative zero: mode=0, all lanes 10'h200, sign=4'b0101 -> all lanes 10'h000, sat=0.
- TC->SM:
  - mode=1, lane0=10'h3FB, sign=0 -> 10'h205.
  - lane1=10'h200, sign=0 -> 10'h3FF, sat[1]=1.
  - lane2=10'h200, sign[2]=1 -> 10'h1FF, sat[2]=1.
  - With COMPLEMENT_SAT_CNT_EN: sat_cnt=2 after acceptance.
- Back-pressure:
  - Stimulus: stream 5 beats with out_ready=0 for 4 cycles from the first out_valid.
  - Expect: in_ready drops after 2 beats buffered, result_num stays stable while stalled, all 5 beats emerge in order once out_ready=1, one per cycle.
- Mixed mode: alternate mode 0/1 on back-to-back beats -> each output matches its own beat's mode; throughput 1 beat/cycle.
- Reset mid-operation: assert rst_n low with 2 beats in flight -> out_valid=0, result_num=0 immediately; in_ready=1 after release; no stale beat emitted.
